// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the byte-producer handshake and the UART write port that the
// round-robin arbiter sits between.
//
// Signals:
//   req_valid     per-requester byte valid
//   req_data      per-requester byte, requester i on bits [8i+7:8i]
//   req_ready     one-hot handshake accept from the arbiter
//   uart_wr_data  byte presented to the UART wr_data input
//   uart_wr_en    single-cycle write strobe to the UART wr_en input
//
// Modports:
//   master  byte sources / UART side (drives valid and data)
//   slave   the arbiter (drives ready and the UART write port)
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_wr_data;
    logic                 uart_wr_en;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  uart_wr_data,
        input  uart_wr_en
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output uart_wr_data,
        output uart_wr_en
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler sharing one UART transmit write port among NUM_REQ
// byte producers. One byte is accepted per handshake, one uart_wr_en pulse is
// issued per byte, and further grants are held off for FRAME_CYCLES cycles
// after each write so the UART is never written while still shifting.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   FRAME_CYCLES  cycles from write strobe to next possible grant (>= 11)
//   CNT_W         width of the per-requester statistics counters
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   enable    low blocks new grants; a frame already in flight completes
//   bus       uart_tx_arbiter_if.slave (req_valid/req_data/req_ready,
//             uart_wr_data/uart_wr_en)
//   gnt_id    index of the requester whose byte is in flight (registered)
//   busy      high while issuing or guarding a frame
//   stat_sel  statistics counter select
//   stat_clr  synchronous clear of all statistics counters
//   stat_cnt  bytes issued for requester stat_sel (combinational read)
//
// Optional feature: define UART_TX_ARB_STATS_EN to build the per-requester
// byte counters; otherwise stat_cnt is tied to zero and stat_sel/stat_clr
// are ignored.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 11,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    input  logic                       stat_clr,
    output logic [CNT_W-1:0]           stat_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int GC_W = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] gnt_q;
    logic [7:0]      data_q;
    logic            wr_en_q;
    logic [GC_W-1:0] guard_q;

    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            grant;
    logic [7:0]      win_data;

    // Round-robin search: scan from last+1 upward (wrapping) and take the
    // first requester presenting a valid byte.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held, even though
    // the state register already reads IDLE.
    assign grant = rst_n && (state_q == IDLE) && enable && found;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. GUARD leaves on the edge where the counter reaches
    // zero, so ISSUE plus GUARD span exactly FRAME_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = GUARD;
            GUARD:   if (guard_q <= GC_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    // Datapath captured at the handshake; the write strobe is the registered
    // grant, so it lines up with the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= ID_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            data_q  <= 8'h00;
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= grant;
            if (grant) begin
                last_q <= win;
                gnt_q  <= win;
                data_q <= win_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_q <= '0;
        end else if (state_q == ISSUE) begin
            guard_q <= GC_W'(FRAME_CYCLES - 1);
        end else if (state_q == GUARD && guard_q != '0) begin
            guard_q <= guard_q - GC_W'(1);
        end
    end

    assign bus.uart_wr_data = data_q;
    assign bus.uart_wr_en   = wr_en_q;
    assign gnt_id           = gnt_q;

`ifdef UART_TX_ARB_STATS_EN
    logic [CNT_W-1:0] stat_q [NUM_REQ];

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (state_q == ISSUE) begin
            stat_q[gnt_q] <= stat_q[gnt_q] + CNT_W'(1);
        end
    end

    assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`else
    logic stats_unused;
    assign stats_unused = ^{stat_sel, stat_clr};
    assign stat_cnt     = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed self-checking bench for uart_tx_arbiter: reset values, single
// requester timing, round-robin order and spacing, enable gating, reset in
// the middle of a frame, and the statistics counters (both builds). When
// UART_TX_ARB_STATS_EN is defined the counters are built 2 bits wide so the
// wrap from all-ones is reached after a handful of bytes.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int FRAME_CYCLES = 11;
`ifdef UART_TX_ARB_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic [1:0]          gnt_id;
    logic                busy;
    logic [1:0]          stat_sel;
    logic                stat_clr;
    logic [TB_CNT_W-1:0] stat_cnt;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int statsOn;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .FRAME_CYCLES (FRAME_CYCLES),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus.slave),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .stat_sel (stat_sel),
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] valid,
                                 input logic [31:0] data);
        enable        = en;
        bus.req_valid = valid;
        bus.req_data  = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (bus.req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput(tag, 32'(n), 32'd0);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput(tag, 32'(n), 32'd0);
    endtask

    task automatic issueByte(input int idx);
        applyStimulus(1'b1, 4'(1 << idx), 32'h13121110);
        waitReady("issue_ready_timeout");
        tick();
        bus.req_valid = '0;
        #1;
        waitIdle("issue_idle_timeout");
    endtask

    initial begin
        int n;
        int wrCount;
        int readyCount;
        int prevIssue;

`ifdef UART_TX_ARB_STATS_EN
        statsOn = 1;
`else
        statsOn = 0;
`endif
        rst_n    = 1'b0;
        stat_sel = 2'd0;
        stat_clr = 1'b0;
        applyStimulus(1'b1, 4'b0000, 32'h0);
        tick();
        tick();

        $display("[TB] reset values");
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_wr_en", 32'(bus.uart_wr_en), 32'h0);
        checkOutput("rst_wr_data", 32'(bus.uart_wr_data), 32'h0);
        checkOutput("rst_gnt_id", 32'(gnt_id), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_stat", 32'(stat_cnt), 32'h0);

        // Single requester: requester 1 with 0xA5.
        $display("[TB] single requester");
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'b0010, 32'h0000A500);
        checkOutput("single_ready", 32'(bus.req_ready), 32'h2);
        tick();
        checkOutput("single_wr_en", 32'(bus.uart_wr_en), 32'h1);
        checkOutput("single_wr_data", 32'(bus.uart_wr_data), 32'hA5);
        checkOutput("single_gnt_id", 32'(gnt_id), 32'h1);
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_ready_issue", 32'(bus.req_ready), 32'h0);
        n = 1;
        wrCount = 1;
        while (bus.req_ready == '0 && n < 40) begin
            tick();
            n++;
            if (bus.uart_wr_en) wrCount++;
        end
        checkOutput("single_next_ready_dist", 32'(n), 32'd12);
        checkOutput("single_wr_en_pulses", 32'(wrCount), 32'd1);
        applyStimulus(1'b1, 4'b0000, 32'h0);
        checkOutput("single_data_hold", 32'(bus.uart_wr_data), 32'hA5);

        // Round-robin from a fresh reset: order 0,1,2,3,0 at 12-cycle spacing.
        $display("[TB] round-robin");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'b1111, 32'h13121110);
        prevIssue = 0;
        for (int g = 0; g < 5; g++) begin
            waitReady("rr_ready_timeout");
            checkOutput("rr_ready", 32'(bus.req_ready), 32'(1 << (g % 4)));
            tick();
            if (g == 4) begin
                enable = 1'b0;
                #1;
            end
            checkOutput("rr_wr_en", 32'(bus.uart_wr_en), 32'h1);
            checkOutput("rr_gnt_id", 32'(gnt_id), 32'(g % 4));
            checkOutput("rr_wr_data", 32'(bus.uart_wr_data), 32'(8'h10 + g % 4));
            if (g > 0) checkOutput("rr_spacing", 32'(cycleCount - prevIssue), 32'd12);
            prevIssue = cycleCount;
            if (g < 4) tick();
        end

        // Enable dropped right after the handshake: the frame still completes
        // with one strobe and no new grant appears.
        $display("[TB] enable gating");
        wrCount = 1;
        readyCount = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.uart_wr_en) wrCount++;
            if (bus.req_ready != '0) readyCount++;
        end
        checkOutput("en_wr_en_pulses", 32'(wrCount), 32'd1);
        checkOutput("en_ready_while_low", 32'(readyCount), 32'd0);
        checkOutput("en_busy_done", 32'(busy), 32'h0);
        applyStimulus(1'b1, 4'b1111, 32'h13121110);
        checkOutput("en_first_grant", 32'(bus.req_ready), 32'h2);
        tick();
        checkOutput("en_gnt_id", 32'(gnt_id), 32'h1);
        checkOutput("en_wr_data", 32'(bus.uart_wr_data), 32'h11);

        // Reset asserted during GUARD.
        $display("[TB] reset mid-frame");
        tick();
        tick();
        tick();
        checkOutput("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_gnt_id", 32'(gnt_id), 32'h0);
        checkOutput("midrst_wr_data", 32'(bus.uart_wr_data), 32'h0);
        checkOutput("midrst_wr_en", 32'(bus.uart_wr_en), 32'h0);
        checkOutput("midrst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_first_ready", 32'(bus.req_ready), 32'h1);
        tick();
        checkOutput("midrst_gnt_id_after", 32'(gnt_id), 32'h0);
        checkOutput("midrst_wr_data_after", 32'(bus.uart_wr_data), 32'h10);
        bus.req_valid = '0;
        #1;
        waitIdle("midrst_idle_timeout");

        // Statistics.
        $display("[TB] statistics");
        stat_sel = 2'd0;
        #1;
        checkOutput("stat_req0_one", 32'(stat_cnt), 32'(statsOn));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        checkOutput("stat_clr_req0", 32'(stat_cnt), 32'h0);
        issueByte(2);
        issueByte(2);
        issueByte(2);
        stat_sel = 2'd2;
        #1;
        checkOutput("stat_req2_three", 32'(stat_cnt), 32'(statsOn * 3));
        stat_sel = 2'd0;
        #1;
        checkOutput("stat_req0_zero", 32'(stat_cnt), 32'h0);
        stat_sel = 2'd2;
        issueByte(2);
        checkOutput("stat_req2_wrap", 32'(stat_cnt), 32'h0);
        issueByte(2);
        checkOutput("stat_req2_one", 32'(stat_cnt), 32'(statsOn));
        applyStimulus(1'b1, 4'b0100, 32'h13121110);
        waitReady("stat_ready_timeout");
        tick();
        stat_clr = 1'b1;
        bus.req_valid = '0;
        tick();
        stat_clr = 1'b0;
        #1;
        checkOutput("stat_clr_priority", 32'(stat_cnt), 32'h0);
        waitIdle("stat_idle_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
